// File: rtl/pll_reset_sequencer_pkg.sv
// Shared types and default timing for the PLL / domain reset sequencer.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4,
        SOFT      = 3'd5
    } state_t;

    localparam int RETRY_W = 4;

    // Defaults are refclk (50 MHz) cycle counts.
    localparam int DEF_NUM_DOMAINS    = 7;
    localparam int DEF_PLL_RST_CYCLES = 16;
    localparam int DEF_LOCK_TIMEOUT   = 50000;
    localparam int DEF_STABLE_CYCLES  = 1024;
    localparam int DEF_STAGE_GAP      = 8;
    localparam int DEF_SOFT_HOLD      = 64;
    localparam int DEF_CNT_W          = 17;

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// Signal bundle between the sequencer, the clocks wrapper (lock in, PLL reset out) and the core.
interface pll_seq_if import pll_seq_pkg::*; #(
    parameter int NUM_DOMAINS = DEF_NUM_DOMAINS
);
    // No valid/ready handshake here: soft_reset_req and lock_lost_clr are single-cycle
    // refclk-domain strobes acted on at the next edge; ready is a level meaning "in RUN".
    logic                   pll_locked;
    logic                   soft_reset_req;
    logic                   lock_lost_clr;
    logic                   pll_rst;
    logic [NUM_DOMAINS-1:0] rst_out;
    logic                   ready;
    logic                   lock_lost;
    logic [RETRY_W-1:0]     retry_count;
    logic [2:0]             state_dbg;

    modport master (
        input  pll_locked, soft_reset_req, lock_lost_clr,
        output pll_rst, rst_out, ready, lock_lost, retry_count, state_dbg
    );

    modport slave (
        output pll_locked, soft_reset_req, lock_lost_clr,
        input  pll_rst, rst_out, ready, lock_lost, retry_count, state_dbg
    );

endinterface

// File: rtl/pll_reset_sequencer_sync2.sv
// Two-flop synchronizer with asynchronous clear, used for the PLL lock flag.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL bring-up and staggered domain reset release, with lock-loss abort and soft reset.
module pll_reset_sequencer import pll_seq_pkg::*; #(
    parameter int NUM_DOMAINS    = DEF_NUM_DOMAINS,
    parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
    parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
    parameter int STAGE_GAP      = DEF_STAGE_GAP,
    parameter int SOFT_HOLD      = DEF_SOFT_HOLD,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic       refclk,
    input  logic       rst,
    pll_seq_if.master  bus
);
    localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    // The WAIT_LOCK cycle that first sees lock counts as qualified cycle one,
    // so STABLE itself needs STABLE_CYCLES-1 more (STABLE_CYCLES must be >= 2).
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 2);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(STAGE_GAP - 1);
    localparam logic [CNT_W-1:0] SOFT_LAST    = CNT_W'(SOFT_HOLD - 1);
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_DOMAINS - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX  = '1;

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [IDX_W-1:0]       idx;
    logic [IDX_W-1:0]       idx_next;
    logic                   lock_s;
    logic                   lock_loss;
    logic                   pll_rst_q;
    logic [NUM_DOMAINS-1:0] rst_q;
    logic                   ready_q;
    logic                   lock_lost_q;
    logic [RETRY_W-1:0]     retry_q;

    sync2 u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (bus.pll_locked),
        .q   (lock_s)
    );

    // idx is the most recently released domain bit while in RELEASE.
    assign idx_next  = idx + 1'b1;
    assign lock_loss = !lock_s && (state == RELEASE || state == RUN || state == SOFT);

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state       <= PLL_RST;
            cnt         <= '0;
            idx         <= '0;
            pll_rst_q   <= 1'b1;
            rst_q       <= '1;
            ready_q     <= 1'b0;
            lock_lost_q <= 1'b0;
            retry_q     <= '0;
        end else if (lock_loss) begin
            // Lock loss outranks a same-cycle soft request and lock_lost_clr.
            state       <= PLL_RST;
            cnt         <= '0;
            pll_rst_q   <= 1'b1;
            rst_q       <= '1;
            ready_q     <= 1'b0;
            lock_lost_q <= 1'b1;
        end else begin
            if (bus.lock_lost_clr) lock_lost_q <= 1'b0;
            case (state)
                PLL_RST: begin
                    if (cnt == RST_LAST) begin
                        state     <= WAIT_LOCK;
                        cnt       <= '0;
                        pll_rst_q <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state <= STABLE;
                        cnt   <= '0;
                    end else if (cnt == TIMEOUT_LAST) begin
                        state     <= PLL_RST;
                        cnt       <= '0;
                        pll_rst_q <= 1'b1;
                        if (retry_q != RETRY_MAX) retry_q <= retry_q + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STABLE: begin
                    if (!lock_s) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == STABLE_LAST) begin
                        state    <= RELEASE;
                        cnt      <= '0;
                        idx      <= '0;
                        rst_q[0] <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    if (cnt == GAP_LAST) begin
                        cnt <= '0;
                        if (idx == IDX_LAST) begin
                            state   <= RUN;
                            ready_q <= 1'b1;
                        end else begin
                            idx             <= idx_next;
                            rst_q[idx_next] <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (bus.soft_reset_req) begin
                        state   <= SOFT;
                        cnt     <= '0;
                        rst_q   <= '1;
                        ready_q <= 1'b0;
                    end
                end
                SOFT: begin
                    if (cnt == SOFT_LAST) begin
                        state    <= RELEASE;
                        cnt      <= '0;
                        idx      <= '0;
                        rst_q[0] <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= PLL_RST;
                    cnt       <= '0;
                    pll_rst_q <= 1'b1;
                    rst_q     <= '1;
                    ready_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pll_rst     = pll_rst_q;
    assign bus.rst_out     = rst_q;
    assign bus.ready       = ready_q;
    assign bus.lock_lost   = lock_lost_q;
    assign bus.retry_count = retry_q;
    assign bus.state_dbg   = state;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with short timing parameters.
module tb_pll_reset_sequencer;
    import pll_seq_pkg::*;

    localparam int ND = 3;

    logic refclk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    pll_seq_if #(.NUM_DOMAINS(ND)) bus ();

    pll_reset_sequencer #(
        .NUM_DOMAINS    (ND),
        .PLL_RST_CYCLES (4),
        .LOCK_TIMEOUT   (20),
        .STABLE_CYCLES  (8),
        .STAGE_GAP      (2),
        .SOFT_HOLD      (5),
        .CNT_W          (17)
    ) dut (
        .refclk (refclk),
        .rst    (rst),
        .bus    (bus)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    task automatic tick(input int n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic pr, input logic [ND-1:0] ro,
                             input logic rdy, input logic ll, input logic [3:0] rc,
                             input logic [2:0] st);
        check({tag, ".pll_rst"},     32'(bus.pll_rst),     32'(pr));
        check({tag, ".rst_out"},     32'(bus.rst_out),     32'(ro));
        check({tag, ".ready"},       32'(bus.ready),       32'(rdy));
        check({tag, ".lock_lost"},   32'(bus.lock_lost),   32'(ll));
        check({tag, ".retry_count"}, 32'(bus.retry_count), 32'(rc));
        check({tag, ".state"},       32'(bus.state_dbg),   32'(st));
    endtask

    task automatic wait_state(input string tag, input logic [2:0] target, input int budget);
        logic found;
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (bus.state_dbg == target) begin
                found = 1'b1;
                break;
            end
            tick(1);
        end
        check({tag, ".reached"}, 32'(found), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst                = 1'b1;
        bus.pll_locked     = 1'b0;
        bus.soft_reset_req = 1'b0;
        bus.lock_lost_clr  = 1'b0;
        tick(3);
        check_all("reset", 1'b1, 3'b111, 1'b0, 1'b0, 4'd0, 3'd0);

        // Lock never arrives: 24-cycle retry period, retry saturates at 15.
        rst = 1'b0;
        tick(23);
        check_all("nolock.c23", 1'b0, 3'b111, 1'b0, 1'b0, 4'd0, 3'd1);
        tick(1);
        check_all("nolock.c24", 1'b1, 3'b111, 1'b0, 1'b0, 4'd1, 3'd0);
        tick(3);
        check("nolock.c27.pll_rst", 32'(bus.pll_rst), 32'd1);
        tick(1);
        check("nolock.c28.pll_rst", 32'(bus.pll_rst), 32'd0);
        tick(20);
        check_all("nolock.c48", 1'b1, 3'b111, 1'b0, 1'b0, 4'd2, 3'd0);
        tick(311);
        check("nolock.c359.retry", 32'(bus.retry_count), 32'd14);
        tick(1);
        check("nolock.c360.retry", 32'(bus.retry_count), 32'd15);
        tick(24);
        check_all("nolock.c384", 1'b1, 3'b111, 1'b0, 1'b0, 4'd15, 3'd0);
        tick(1);
        rst = 1'b1;
        #1;
        check_all("nolock.async_rst", 1'b1, 3'b111, 1'b0, 1'b0, 4'd0, 3'd0);
        tick(2);

        // Nominal bring-up, lock raised at cycle 10.
        rst = 1'b0;
        check_all("nom.c0", 1'b1, 3'b111, 1'b0, 1'b0, 4'd0, 3'd0);
        tick(3);
        check("nom.c3.pll_rst", 32'(bus.pll_rst), 32'd1);
        tick(1);
        check_all("nom.c4", 1'b0, 3'b111, 1'b0, 1'b0, 4'd0, 3'd1);
        tick(6);
        bus.pll_locked = 1'b1;
        tick(3);
        check("nom.c13.state", 32'(bus.state_dbg), 32'd2);
        tick(6);
        check_all("nom.c19", 1'b0, 3'b111, 1'b0, 1'b0, 4'd0, 3'd2);
        tick(1);
        check_all("nom.c20", 1'b0, 3'b110, 1'b0, 1'b0, 4'd0, 3'd3);
        tick(1);
        check("nom.c21.rst_out", 32'(bus.rst_out), 32'b110);
        tick(1);
        check("nom.c22.rst_out", 32'(bus.rst_out), 32'b100);
        tick(2);
        check_all("nom.c24", 1'b0, 3'b000, 1'b0, 1'b0, 4'd0, 3'd3);
        tick(1);
        check("nom.c25.ready", 32'(bus.ready), 32'd0);
        tick(1);
        check_all("nom.c26", 1'b0, 3'b000, 1'b1, 1'b0, 4'd0, 3'd4);

        // Soft reset from RUN.
        bus.soft_reset_req = 1'b1;
        tick(1);
        bus.soft_reset_req = 1'b0;
        check_all("soft.r1", 1'b0, 3'b111, 1'b0, 1'b0, 4'd0, 3'd5);
        tick(4);
        check_all("soft.r5", 1'b0, 3'b111, 1'b0, 1'b0, 4'd0, 3'd5);
        tick(1);
        check_all("soft.r6", 1'b0, 3'b110, 1'b0, 1'b0, 4'd0, 3'd3);
        tick(2);
        check("soft.r8.rst_out", 32'(bus.rst_out), 32'b100);
        tick(2);
        check("soft.r10.rst_out", 32'(bus.rst_out), 32'b000);
        tick(2);
        check_all("soft.r12", 1'b0, 3'b000, 1'b1, 1'b0, 4'd0, 3'd4);

        // Lock loss in RUN, then clear lock_lost.
        bus.pll_locked = 1'b0;
        tick(2);
        check_all("loss.x2", 1'b0, 3'b000, 1'b1, 1'b0, 4'd0, 3'd4);
        tick(1);
        check_all("loss.x3", 1'b1, 3'b111, 1'b0, 1'b1, 4'd0, 3'd0);
        tick(3);
        check("loss.x6.pll_rst", 32'(bus.pll_rst), 32'd1);
        tick(1);
        check_all("loss.x7", 1'b0, 3'b111, 1'b0, 1'b1, 4'd0, 3'd1);
        bus.lock_lost_clr = 1'b1;
        tick(1);
        bus.lock_lost_clr = 1'b0;
        check("loss.clr", 32'(bus.lock_lost), 32'd0);

        // Lock loss, soft request and lock_lost_clr all in one cycle.
        bus.pll_locked = 1'b1;
        wait_state("combo.up", 3'd4, 40);
        check("combo.up.ready", 32'(bus.ready), 32'd1);
        bus.pll_locked = 1'b0;
        tick(2);
        bus.soft_reset_req = 1'b1;
        bus.lock_lost_clr  = 1'b1;
        tick(1);
        bus.soft_reset_req = 1'b0;
        bus.lock_lost_clr  = 1'b0;
        check_all("combo.hit", 1'b1, 3'b111, 1'b0, 1'b1, 4'd0, 3'd0);
        bus.lock_lost_clr = 1'b1;
        tick(1);
        bus.lock_lost_clr = 1'b0;
        check("combo.clr", 32'(bus.lock_lost), 32'd0);
        wait_state("glitch.wait", 3'd1, 10);

        // One-cycle lock glitch at STABLE count 5 restarts qualification.
        bus.pll_locked = 1'b1;
        tick(6);
        bus.pll_locked = 1'b0;
        tick(1);
        bus.pll_locked = 1'b1;
        tick(1);
        check("glitch.y8.state", 32'(bus.state_dbg), 32'd2);
        tick(1);
        check_all("glitch.y9", 1'b0, 3'b111, 1'b0, 1'b0, 4'd0, 3'd1);
        tick(1);
        check("glitch.y10.state", 32'(bus.state_dbg), 32'd2);
        tick(6);
        check_all("glitch.y16", 1'b0, 3'b111, 1'b0, 1'b0, 4'd0, 3'd2);
        tick(1);
        check_all("glitch.y17", 1'b0, 3'b110, 1'b0, 1'b0, 4'd0, 3'd3);
        tick(1);
        check("glitch.y18.rst_out", 32'(bus.rst_out), 32'b110);

        // Async reset in RELEASE, outputs return without a clock edge.
        rst = 1'b1;
        #1;
        check_all("arst.now", 1'b1, 3'b111, 1'b0, 1'b0, 4'd0, 3'd0);
        tick(2);
        rst = 1'b0;
        check("arst.c0.pll_rst", 32'(bus.pll_rst), 32'd1);
        tick(3);
        check("arst.c3.pll_rst", 32'(bus.pll_rst), 32'd1);
        tick(1);
        check_all("arst.c4", 1'b0, 3'b111, 1'b0, 1'b0, 4'd0, 3'd1);
        tick(1);
        check("arst.c5.state", 32'(bus.state_dbg), 32'd2);
        tick(6);
        check_all("arst.c11", 1'b0, 3'b111, 1'b0, 1'b0, 4'd0, 3'd2);
        tick(1);
        check_all("arst.c12", 1'b0, 3'b110, 1'b0, 1'b0, 4'd0, 3'd3);
        tick(6);
        check_all("arst.c18", 1'b0, 3'b000, 1'b1, 1'b0, 4'd0, 3'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
